// File: rtl/data_mem_responder.sv
// data_mem_responder: data-bus target over a fixed-latency BRAM with little-endian lane steering
// and rejection of misaligned or out-of-range accesses.
module data_mem_responder #(
    parameter int DEPTH_WORDS  = 16384,
    parameter int READ_LATENCY = 2
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [31:0]                    addr,
    input  logic [1:0]                     mem_width,
    input  logic                           dispatch_read,
    input  logic                           dispatch_write,
    input  logic [31:0]                    write_data,
    output logic [31:0]                    read_data,
    output logic                           busy,
    output logic                           err_pulse,
    output logic [$clog2(DEPTH_WORDS)-1:0] bram_addr,
    output logic [3:0]                     bram_we,
    output logic [31:0]                    bram_wdata,
    input  logic [31:0]                    bram_rdata
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [1:0] LAST = 2'(READ_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, DONE_ERR} state_t;

    state_t          r_state, w_next;
    logic            r_busy, r_err;
    logic [31:0]     r_rdata, r_wdata, w_wd_st, w_shift, w_ext;
    logic [AW-1:0]   r_addr;
    logic [3:0]      r_we, w_we_st;
    logic [1:0]      r_off, r_width, r_cnt;
    logic            w_req, w_mis, w_oor, w_bad, w_start_rd;

    assign w_req      = r_state == IDLE && !r_busy && (dispatch_read || dispatch_write);
    assign w_mis      = mem_width == 2'd3 || (mem_width == 2'd1 && addr[0]) ||
                        (mem_width == 2'd2 && addr[1:0] != 2'd0);
    assign w_oor      = addr[31:2] >= 30'(DEPTH_WORDS);
    assign w_bad      = w_mis || w_oor;
    // The read address reaches the RAM in the accept cycle so data lands on the last wait cycle.
    assign w_start_rd = rst_in && w_req && !w_bad && !dispatch_write;

    assign w_we_st = mem_width == 2'd0 ? 4'b0001 << addr[1:0] :
                     mem_width == 2'd1 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wd_st = mem_width == 2'd0 ? {4{write_data[7:0]}} :
                     mem_width == 2'd1 ? {2{write_data[15:0]}} : write_data;

    assign w_shift = bram_rdata >> {r_off, 3'b000};
    assign w_ext   = r_width == 2'd0 ? {24'd0, w_shift[7:0]} :
                     r_width == 2'd1 ? {16'd0, w_shift[15:0]} : w_shift;

    assign busy       = r_busy;
    assign err_pulse  = r_err;
    assign read_data  = r_rdata;
    assign bram_we    = r_we;
    assign bram_wdata = r_wdata;
    assign bram_addr  = w_start_rd ? addr[AW+1:2] : r_addr;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = !w_req ? IDLE : w_bad ? DONE_ERR :
                                dispatch_write ? WRITE : READ_WAIT;
            READ_WAIT: w_next = r_cnt == LAST ? IDLE : READ_WAIT;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_wdata <= '0;
            r_addr  <= '0;
            r_we    <= '0;
            r_off   <= '0;
            r_width <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= w_next != IDLE;
            r_err   <= w_req && (w_bad || (dispatch_read && dispatch_write));
            r_we    <= '0;
            r_cnt   <= r_state == READ_WAIT ? r_cnt + 2'd1 : 2'd0;
            if (w_req && !w_bad) begin
                r_addr  <= addr[AW+1:2];
                r_off   <= addr[1:0];
                r_width <= mem_width;
            end
            if (w_req && !w_bad && dispatch_write) begin
                r_we    <= w_we_st;
                r_wdata <= w_wd_st;
            end
            if (w_req && w_bad && !dispatch_write)
                r_rdata <= '0;
            if (r_state == READ_WAIT && r_cnt == LAST)
                r_rdata <= w_ext;
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: byte-addressed reference memory drives per-cycle expectations for
// busy, err_pulse, bram_we and read_data; directed loads pin the model to literal values.
module tb_data_mem_responder;
    localparam int DEPTH = 16384;
    localparam int RL    = 2;
    localparam int AW    = $clog2(DEPTH);

    logic          clk_in = 1'b0, rst_in = 1'b0;
    logic [31:0]   addr = '0, write_data = '0, read_data, bram_wdata, bram_rdata;
    logic [1:0]    mem_width = '0;
    logic          dispatch_read = 1'b0, dispatch_write = 1'b0, busy, err_pulse;
    logic [AW-1:0] bram_addr;
    logic [3:0]    bram_we;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(RL)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .addr(addr), .mem_width(mem_width),
        .dispatch_read(dispatch_read), .dispatch_write(dispatch_write),
        .write_data(write_data), .read_data(read_data), .busy(busy),
        .err_pulse(err_pulse), .bram_addr(bram_addr), .bram_we(bram_we),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
    );

    always #5 clk_in = ~clk_in;

    logic [31:0] ram [0:DEPTH-1];
    logic [31:0] pipe [0:RL-1];
    logic        clr = 1'b1;
    assign bram_rdata = pipe[RL-1];

    always @(posedge clk_in) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
            for (int i = 0; i < RL; i++) pipe[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (bram_we[i]) ram[bram_addr][8*i +: 8] <= bram_wdata[8*i +: 8];
            pipe[0] <= ram[bram_addr];
            for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
        end
    end

    logic [7:0]  mm [0:1023];
    logic        chk_en = 1'b0, exp_busy = 1'b0, exp_err = 1'b0;
    logic [3:0]  exp_we = '0;
    logic [31:0] exp_rdata = '0;
    int          n_cmp = 0, n_bad = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic bit is_bad(input logic [31:0] a, input logic [1:0] w);
        int sz;
        sz = 1 << w;
        return w == 2'd3 || (a % sz) != 0 || a >= 32'(DEPTH * 4);
    endfunction

    function automatic logic [3:0] lanes(input logic [31:0] a, input logic [1:0] w);
        logic [3:0] m;
        m = '0;
        for (int i = 0; i < (1 << w); i++) m[(a + i) % 4] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < (1 << w); i++) r = r | (32'(mm[a + i]) << (8 * i));
        return r;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
        for (int i = 0; i < (1 << w); i++) mm[a + i] = d[8*i +: 8];
    endtask

    always @(negedge clk_in) begin
        if (chk_en) begin
            cmp("busy", 32'(busy), 32'(exp_busy));
            cmp("err_pulse", 32'(err_pulse), 32'(exp_err));
            cmp("bram_we", 32'(bram_we), 32'(exp_we));
            cmp("read_data", read_data, exp_rdata);
        end
    end

    task automatic req(input bit rd, input bit wr, input logic [31:0] a, input logic [1:0] w,
                       input logic [31:0] d, input bit junk);
        bit bad;
        int n;
        logic [3:0] we;
        bad = is_bad(a, w);
        n   = (bad || wr) ? 1 : RL;
        we  = (wr && !bad) ? lanes(a, w) : 4'b0;
        addr = a; mem_width = w; write_data = d;
        dispatch_read = rd; dispatch_write = wr;
        exp_busy = 1'b0; exp_err = 1'b0; exp_we = '0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk_in); #1;
            dispatch_read = 1'b0; dispatch_write = junk;
            if (junk) begin
                addr = 32'h300; mem_width = 2'd2; write_data = 32'hBADBAD00;
            end
            exp_busy = 1'b1;
            exp_err  = (k == 1) && (bad || (rd && wr));
            exp_we   = (k == 1) ? we : 4'b0;
            if (k == 1 && bad && rd && !wr) exp_rdata = '0;
        end
        @(posedge clk_in); #1;
        dispatch_read = 1'b0; dispatch_write = 1'b0;
        exp_busy = 1'b0; exp_err = 1'b0; exp_we = '0;
        if (wr && !bad) model_write(a, w, d);
        if (rd && !wr && !bad) exp_rdata = model_read(a, w);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mm[i] = '0;
        repeat (2) @(posedge clk_in);
        #1;
        cmp("rst_busy", 32'(busy), 32'd0);
        cmp("rst_read_data", read_data, 32'd0);
        cmp("rst_err", 32'(err_pulse), 32'd0);
        cmp("rst_we", 32'(bram_we), 32'd0);
        cmp("rst_bram_addr", 32'(bram_addr), 32'd0);
        cmp("rst_wdata", bram_wdata, 32'd0);
        clr = 1'b0;
        rst_in = 1'b1;
        chk_en = 1'b1;
        @(posedge clk_in); #1;

        req(0, 1, 32'h100, 2'd2, 32'hDEADBEEF, 0);
        req(1, 0, 32'h100, 2'd2, 32'h0, 0);
        cmp("pin_dword", read_data, 32'hDEADBEEF);
        req(0, 1, 32'h101, 2'd0, 32'h000000AA, 0);
        req(1, 0, 32'h100, 2'd2, 32'h0, 0);
        cmp("pin_byte_merge", read_data, 32'hDEADAAEF);
        req(1, 0, 32'h102, 2'd1, 32'h0, 0);
        cmp("pin_word_hi", read_data, 32'h0000DEAD);
        req(1, 0, 32'h101, 2'd0, 32'h0, 0);
        cmp("pin_byte1", read_data, 32'h000000AA);
        req(1, 0, 32'h103, 2'd0, 32'h0, 0);
        cmp("pin_byte3", read_data, 32'h000000DE);

        req(0, 1, 32'h103, 2'd1, 32'h00005555, 0);
        req(1, 0, 32'h102, 2'd2, 32'h0, 0);
        cmp("pin_err_rdata", read_data, 32'h0);
        req(1, 0, 32'h100, 2'd2, 32'h0, 0);
        req(1, 0, 32'(DEPTH * 4), 2'd2, 32'h0, 0);
        req(1, 0, 32'h100, 2'd3, 32'h0, 0);
        req(1, 0, 32'h100, 2'd2, 32'h0, 0);
        cmp("pin_after_errs", read_data, 32'hDEADAAEF);

        req(1, 1, 32'h200, 2'd2, 32'h12345678, 0);
        req(1, 0, 32'h200, 2'd2, 32'h0, 1);
        cmp("pin_both", read_data, 32'h12345678);
        req(1, 0, 32'h300, 2'd2, 32'h0, 0);
        cmp("pin_ignored_wr", read_data, 32'h0);
        req(0, 1, 32'h202, 2'd1, 32'h0000BEEF, 0);
        req(1, 0, 32'h200, 2'd2, 32'h0, 0);
        cmp("pin_word_upper", read_data, 32'hBEEF5678);

        chk_en = 1'b0;
        addr = 32'h104; mem_width = 2'd2; dispatch_read = 1'b1;
        @(posedge clk_in); #1;
        dispatch_read = 1'b0;
        cmp("mid_busy", 32'(busy), 32'd1);
        #2 rst_in = 1'b0;
        #1;
        cmp("async_busy", 32'(busy), 32'd0);
        cmp("async_rdata", read_data, 32'd0);
        cmp("async_we", 32'(bram_we), 32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        exp_rdata = '0; exp_busy = 1'b0; exp_err = 1'b0; exp_we = '0;
        chk_en = 1'b1;
        @(posedge clk_in); #1;
        req(1, 0, 32'h100, 2'd2, 32'h0, 0);
        cmp("pin_after_reset", read_data, 32'hDEADAAEF);
        repeat (2) @(posedge clk_in);
        #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
